// File: rtl/seq_multiplier_pkg.sv
// Shared constants and state encoding for the shift-add multiplier.
// SEQ_MULT_SIGNED_EN enables the signed (two's complement) path.
package seq_multiplier_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;
  localparam int ITER  = WIDTH;

`ifdef SEQ_MULT_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_NEG_A  = 3'd1,
    S_NEG_B  = 3'd2,
    S_RUN    = 3'd3,
    S_NEG_LO = 3'd4,
    S_NEG_HI = 3'd5,
    S_DONE   = 3'd6
  } state_e;

endpackage

// File: rtl/seq_multiplier_adder.sv
// Shared 32-bit adder of the MULT datapath.
// Carry-out is reconstructed by the user from the operand and sum MSBs.
module adder
  import seq_multiplier_pkg::*;
(
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic             cin,
  output logic [WIDTH-1:0] sum
);

  assign sum = inp1 + inp2 + {{(WIDTH-1){1'b0}}, cin};

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier, one adder shared by all steps.
// SEQ_MULT_SIGNED_EN enables operand/result negation states.
module seq_multiplier
  import seq_multiplier_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   prod_hi_q;
  logic [WIDTH-1:0]   prod_lo_q;
  logic               sign_q;
  logic               z_q;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic               add_c;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [WIDTH-1:0]   run_hi;
  logic [WIDTH-1:0]   run_lo;
  logic               sgn_en;

  assign sgn_en = sgn & SIGNED_EN;

  always_comb begin
    add_a = '0;
    add_b = '0;
    add_c = 1'b0;
    case (state_q)
      S_NEG_A: begin
        add_a = ~mcand_q;
        add_c = 1'b1;
      end
      S_NEG_B: begin
        add_a = ~lo_q;
        add_c = 1'b1;
      end
      S_RUN: begin
        add_a = hi_q;
        add_b = lo_q[0] ? mcand_q : '0;
      end
      S_NEG_LO: begin
        add_a = ~lo_q;
        add_c = 1'b1;
      end
      S_NEG_HI: begin
        add_a = ~hi_q;
        add_c = z_q;
      end
      default: ;
    endcase
  end

  adder u_adder (
    .inp1 (add_a),
    .inp2 (add_b),
    .cin  (add_c),
    .sum  (sum)
  );

  // The adder has no carry-out port; rebuild it from the MSBs.
  assign carry = (hi_q[WIDTH-1] & add_b[WIDTH-1])
               | ((hi_q[WIDTH-1] ^ add_b[WIDTH-1]) & ~sum[WIDTH-1]);
  assign run_hi = {carry, sum[WIDTH-1:1]};
  assign run_lo = {sum[0], lo_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
      sign_q    <= 1'b0;
      z_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q <= op_a;
            hi_q    <= '0;
            lo_q    <= op_b;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= sgn_en ? S_NEG_A : S_RUN;
          end
        end
        S_NEG_A: begin
          if (mcand_q[WIDTH-1]) mcand_q <= sum;
          sign_q  <= mcand_q[WIDTH-1] ^ lo_q[WIDTH-1];
          state_q <= S_NEG_B;
        end
        S_NEG_B: begin
          if (lo_q[WIDTH-1]) lo_q <= sum;
          state_q <= S_RUN;
        end
        S_RUN: begin
          hi_q  <= run_hi;
          lo_q  <= run_lo;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(ITER - 1)) begin
            if (sign_q) begin
              state_q <= S_NEG_LO;
            end else begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              prod_hi_q <= run_hi;
              prod_lo_q <= run_lo;
            end
          end
        end
        S_NEG_LO: begin
          lo_q    <= sum;
          z_q     <= (lo_q == '0);
          state_q <= S_NEG_HI;
        end
        S_NEG_HI: begin
          hi_q      <= sum;
          state_q   <= S_DONE;
          done_q    <= 1'b1;
          prod_hi_q <= sum;
          prod_lo_q <= lo_q;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign prod_hi = prod_hi_q;
  assign prod_lo = prod_lo_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier against an arithmetic model.
// Honours SEQ_MULT_SIGNED_EN the same way as the design build.
module tb_seq_multiplier;

`ifdef SEQ_MULT_SIGNED_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] prod_hi;
  logic [31:0] prod_lo;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] last_prod = '0;

  seq_multiplier dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sgn     (sgn),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .prod_hi (prod_hi),
    .prod_lo (prod_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input bit s);
    longint sa;
    longint sb;
    logic [63:0] ua;
    logic [63:0] ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  function automatic int latency(input logic [31:0] a,
                                 input logic [31:0] b,
                                 input bit s);
    if (!s) return 33;
    return (a[31] ^ b[31]) ? 37 : 35;
  endfunction

  // One full operation; optional start pulse during RUN and in DONE.
  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input bit s, input int glitch_at,
                     input bit start_in_done);
    bit          se;
    int          cyc;
    bit          got;
    logic [63:0] exp;
    se  = s & SEN;
    exp = model(a, b, se);
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    op_a  = a;
    op_b  = b;
    sgn   = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
    sgn   = ~s;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        got = 1'b1;
      end else begin
        chk("busy_run", 64'(busy), 64'd1);
        chk("prod_stable", {prod_hi, prod_lo}, last_prod);
        start = (cyc == glitch_at);
      end
    end
    start = 1'b0;
    chk("done_seen", 64'(got), 64'd1);
    chk("latency", 64'(cyc), 64'(latency(a, b, se)));
    chk("product", {prod_hi, prod_lo}, exp);
    chk("busy_done", 64'(busy), 64'd1);
    if (start_in_done) begin
      op_a  = 32'd3;
      op_b  = 32'd3;
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_width", 64'(done), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("prod_hold", {prod_hi, prod_lo}, exp);
    last_prod = exp;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    rst   = 1'b1;
    start = 1'b0;
    sgn   = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_prod", {prod_hi, prod_lo}, 64'd0);
    rst = 1'b0;

    run(32'd7, 32'd6, 1'b0, -1, 1'b0);
    chk("t1_prod", {prod_hi, prod_lo}, 64'h0000_0000_0000_002A);
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, 1'b0);
    chk("t2_prod", {prod_hi, prod_lo}, 64'hFFFF_FFFE_0000_0001);
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, -1, 1'b0);
    run(32'hFFFF_FFFD, 32'd5, 1'b1, -1, 1'b0);
    run(32'h8000_0000, 32'h8000_0000, 1'b1, -1, 1'b0);
    run(32'd0, 32'hFFFF_FFFB, 1'b1, -1, 1'b0);
    run(32'd1234, 32'd5678, 1'b0, 12, 1'b1);
    run(32'hFFFF_FFF9, 32'd9, 1'b1, 20, 1'b1);

    // Reset during RUN aborts without a done pulse.
    @(negedge clk);
    op_a  = 32'd100;
    op_b  = 32'd200;
    sgn   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_prod", {prod_hi, prod_lo}, 64'd0);
    last_prod = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("abort_nodone", 64'(done), 64'd0);
    end
    run(32'd100, 32'd200, 1'b0, -1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) ra = $urandom_range(0, 15);
      if (i % 5 == 1) rb = 32'hFFFF_FFFF - $urandom_range(0, 3);
      run(ra, rb, bit'($urandom_range(0, 1)), -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
